// File: rtl/sram_access_ctrl.sv
// ---------------------------------------------------------------------------
// sram_access_ctrl
// Single-port word SRAM behind a small access controller. A single read or
// write request is accepted in FREE. The controller then spends exactly
// LATENCY cycles in BUSY, signals completion for one ACCESS cycle, and
// returns to FREE. sram_buffer sequences its transfers by watching
// sram_state, so that encoding and its timing form the whole handshake.
//
// Ports
//   clk         in   1       system clock, rising edge
//   n_rst       in   1       asynchronous active-low reset
//   wen         in   1       write request, sampled only in FREE
//   ren         in   1       read request, sampled only in FREE
//   addr        in   ADDR_W  word address, sampled with the request
//   wdata       in   DATA_W  write data, sampled with the request
//   rdata       out  DATA_W  read result, updated only when a read completes
//   sram_state  out  2       00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR
// ---------------------------------------------------------------------------
module sram_access_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wen,
  input  logic              ren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        sram_state
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'b00,
    ST_BUSY   = 2'b01,
    ST_ACCESS = 2'b10,
    ST_ERROR  = 2'b11
  } state_t;

  // One extra bit so DEPTH == 2**ADDR_W is representable in the comparison.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      LAT_LAST  = 4'(LATENCY - 1);

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                op_write_reg, op_write_next;
  logic [ADDR_W-1:0]   addr_q_reg, addr_q_next;
  logic [DATA_W-1:0]   wdata_q_reg, wdata_q_next;
  logic [DATA_W-1:0]   rdata_reg;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic addr_ok;
  logic commit;

  assign addr_ok = ({1'b0, addr} < DEPTH_LIM);
  // The memory operation happens on the final BUSY cycle, so the result is
  // visible exactly when sram_state reads ACCESS.
  assign commit  = (state_reg == ST_BUSY) && (cnt_reg == LAT_LAST);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    op_write_next = op_write_reg;
    addr_q_next   = addr_q_reg;
    wdata_q_next  = wdata_q_reg;
    case (state_reg)
      ST_FREE: begin
        if ((wen ^ ren) && addr_ok) begin
          op_write_next = wen;
          addr_q_next   = addr;
          wdata_q_next  = wdata;
          cnt_next      = 4'd0;
          state_next    = ST_BUSY;
        end else if (wen | ren) begin
          // Both requests at once, or a single request to an illegal address.
          state_next = ST_ERROR;
        end
      end
      ST_BUSY: begin
        cnt_next = cnt_reg + 4'd1;
        if (commit) begin
          state_next = ST_ACCESS;
        end
      end
      // ACCESS never chains into a new request; a held request is picked up
      // again in the following FREE cycle.
      ST_ACCESS: state_next = ST_FREE;
      ST_ERROR:  state_next = ST_FREE;
      default:   state_next = ST_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg    <= ST_FREE;
      cnt_reg      <= 4'd0;
      op_write_reg <= 1'b0;
      addr_q_reg   <= '0;
      wdata_q_reg  <= '0;
      rdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      op_write_reg <= op_write_next;
      addr_q_reg   <= addr_q_next;
      wdata_q_reg  <= wdata_q_next;
      if (commit && !op_write_reg) begin
        rdata_reg <= mem[addr_q_reg];
      end
    end
  end

  // Storage is deliberately left out of reset so its contents survive it.
  // While n_rst is low the state register is FREE, so commit cannot fire and
  // an interrupted write is simply dropped.
  always_ff @(posedge clk) begin
    if (commit && op_write_reg) begin
      mem[addr_q_reg] <= wdata_q_reg;
    end
  end

  assign rdata      = rdata_reg;
  assign sram_state = state_reg;

endmodule
